// File: rtl/alu_wb_pkg.sv
// Shared types for the ALU writeback path: condition codes, flag bit positions
// and the buffered writeback entry layout.
package alu_wb_pkg;

    localparam int N      = 24;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_LT = 4'd3,
        COND_GE = 4'd4,
        COND_CS = 4'd5,
        COND_CC = 4'd6,
        COND_MI = 4'd7,
        COND_PL = 4'd8,
        COND_GT = 4'd9,
        COND_LE = 4'd10
    } cond_e;

    typedef struct packed {
        logic [N-1:0]      result;
        logic [3:0]        flags;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              set_flags;
        cond_e             cond;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_unit_cond_check.sv
// Combinational condition-code evaluator against an NZCV flag vector.
// Codes outside the defined set never pass; shared with the branch unit.
module cond_check
    import alu_wb_pkg::*;
(
    input  cond_e      cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n_s, z_s, c_s, v_s;

    // Decode the condition against the flag bits.
    always_comb begin
        n_s    = flags_i[FLAG_N];
        z_s    = flags_i[FLAG_Z];
        c_s    = flags_i[FLAG_C];
        v_s    = flags_i[FLAG_V];
        pass_o = 1'b0;
        case (cond_i)
            COND_AL: pass_o = 1'b1;
            COND_EQ: pass_o = z_s;
            COND_NE: pass_o = !z_s;
            COND_LT: pass_o = (n_s != v_s);
            COND_GE: pass_o = (n_s == v_s);
            COND_CS: pass_o = c_s;
            COND_CC: pass_o = !c_s;
            COND_MI: pass_o = n_s;
            COND_PL: pass_o = !n_s;
            COND_GT: pass_o = !z_s && (n_s == v_s);
            COND_LE: pass_o = z_s || (n_s != v_s);
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback_unit.sv
// In-order writeback buffer between the EX-stage ALUs and the register file / flag register.
// Optional macro WB_BYPASS_EN lets an op arriving at an empty, unstalled unit commit the same cycle.
module alu_writeback_unit
    import alu_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      in_result,
    input  logic [3:0]        in_flags,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic              in_set_flags,
    input  logic [3:0]        in_cond,
    input  logic              rf_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [N-1:0]      rf_wdata,
    output logic [3:0]        flags_q,
    output logic [15:0]       squash_cnt
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_addr_q;
    logic [N-1:0]      rf_wdata_q;
    logic [3:0]        flag_reg_q;
    logic [15:0]       squash_q;

    wb_entry_t in_entry_s, head_s;
    logic      empty_s, ready_s, bypass_s, fifo_push_s, fifo_pop_s, commit_s, pass_s;

    // Handshake, bypass selection and next pointer/count values.
    always_comb begin
        in_entry_s = '{result: in_result, flags: in_flags, rd: in_rd, we: in_we,
                       set_flags: in_set_flags, cond: cond_e'(in_cond)};
        empty_s    = (count_q == {CNT_W{1'b0}});
        // No pass-through when full: a same-cycle pop does not open a slot.
        ready_s    = (count_q != FULL_CNT);
`ifdef WB_BYPASS_EN
        bypass_s   = empty_s && !rf_stall && in_valid;
`else
        bypass_s   = 1'b0;
`endif
        fifo_pop_s  = !empty_s && !rf_stall;
        fifo_push_s = in_valid && ready_s && !bypass_s;
        commit_s    = fifo_pop_s || bypass_s;
        if (bypass_s) begin
            head_s = in_entry_s;
        end else begin
            head_s = mem_q[rd_ptr_q];
        end
        wr_ptr_d = fifo_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = fifo_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({fifo_push_s, fifo_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    cond_check u_cond_check (
        .cond_i  (head_s.cond),
        .flags_i (flag_reg_q),
        .pass_o  (pass_s)
    );

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (fifo_push_s) begin
            mem_q[wr_ptr_q] <= in_entry_s;
        end
    end

    // FIFO control, commit/squash of the head op, flag register and squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            rf_we_q    <= 1'b0;
            rf_addr_q  <= {ADDR_W{1'b0}};
            rf_wdata_q <= {N{1'b0}};
            flag_reg_q <= 4'b0000;
            squash_q   <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rf_we_q  <= commit_s && pass_s && head_s.we;
            if (commit_s && pass_s) begin
                if (head_s.we) begin
                    rf_addr_q  <= head_s.rd;
                    rf_wdata_q <= head_s.result;
                end
                if (head_s.set_flags) begin
                    flag_reg_q <= head_s.flags;
                end
            end else if (commit_s && (squash_q != 16'hFFFF)) begin
                squash_q <= squash_q + 16'd1;
            end
        end
    end

    assign in_ready   = ready_s;
    assign rf_we      = rf_we_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wdata   = rf_wdata_q;
    assign flags_q    = flag_reg_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Self-checking bench for alu_writeback_unit: directed scenarios plus randomized
// traffic scored against an in-order commit model.
module tb_alu_writeback_unit;
    import alu_wb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      in_result;
    logic [3:0]        in_flags;
    logic [ADDR_W-1:0] in_rd;
    logic              in_we;
    logic              in_set_flags;
    logic [3:0]        in_cond;
    logic              rf_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [N-1:0]      rf_wdata;
    logic [3:0]        flags_q;
    logic [15:0]       squash_cnt;

    logic stall_force = 1'b0;
    logic stall_rand  = 1'b0;
    logic rand_en     = 1'b0;
    assign rf_stall = stall_force | (rand_en & stall_rand);

    alu_writeback_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd), .in_we(in_we),
        .in_set_flags(in_set_flags), .in_cond(in_cond), .rf_stall(rf_stall),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .flags_q(flags_q), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1 stall_rand = ($urandom_range(0, 3) == 0);
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [N-1:0]      data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    logic [3:0] m_flags;
    int   m_squash;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Record every write strobe seen by the register file.
    always @(negedge clk) begin
        if (rst_n && rf_we) obs_q.push_back('{addr: rf_addr, data: rf_wdata});
    end

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return z;
            4'd2:    return !z;
            4'd3:    return n ^ v;
            4'd4:    return !(n ^ v);
            4'd5:    return cy;
            4'd6:    return !cy;
            4'd7:    return n;
            4'd8:    return !n;
            4'd9:    return !z && !(n ^ v);
            4'd10:   return z || (n ^ v);
            default: return 1'b0;
        endcase
    endfunction

    // Ops commit strictly in order, so outcomes can be resolved at acceptance time.
    task automatic model_accept(input logic [N-1:0] res, input logic [3:0] fl,
                                input logic [ADDR_W-1:0] rd, input logic we,
                                input logic sf, input logic [3:0] cond);
        if (cond_holds(cond, m_flags)) begin
            if (we) exp_q.push_back('{addr: rd, data: res});
            if (sf) m_flags = fl;
        end else if (m_squash < 65535) begin
            m_squash++;
        end
    endtask

    task automatic model_reset();
        m_flags  = 4'b0000;
        m_squash = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic push_op(input logic [N-1:0] res, input logic [3:0] fl,
                           input logic [ADDR_W-1:0] rd, input logic we,
                           input logic sf, input logic [3:0] cond);
        bit ok = 1'b0;
        in_result = res; in_flags = fl; in_rd = rd; in_we = we;
        in_set_flags = sf; in_cond = cond; in_valid = 1'b1;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                model_accept(res, fl, rd, we, sf, cond);
            end
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%0b required 1 within 64 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_rd = '0;
        in_we = 1'b0; in_set_flags = 1'b0; in_cond = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rf_we, rf_addr, rf_wdata, flags_q, squash_cnt, in_ready} !==
            {1'b0, {ADDR_W{1'b0}}, {N{1'b0}}, 4'b0000, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: we=%0b addr=%0h data=%0h flags=%0h sq=%0h rdy=%0b required 0/0/0/0/0/1",
                     rf_we, rf_addr, rf_wdata, flags_q, squash_cnt, in_ready);
        end
        rst_n = 1'b1;
        idle(1);
        stall_force = 1'b1;
        for (int i = 0; i < 3; i++) push_op(N'(24'h00AA00 + i), 4'b1111, ADDR_W'(i + 1), 1'b1, 1'b1, 4'd0);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({rf_we, flags_q, in_ready} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_midburst: we=%0b flags=%0h rdy=%0b required 0/0/1", rf_we, flags_q, in_ready);
        end
        model_reset();
        #10 rst_n = 1'b1;
        stall_force = 1'b0;
        idle(6);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_write: writes=%0d required 0", obs_q.size());
        end
    endtask

    task automatic test_basic_write();
        push_op(24'h001234, 4'b0000, 4'd5, 1'b1, 1'b0, 4'd0);
`ifndef WB_BYPASS_EN
        @(negedge clk);
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: rf_we=%0b at T+1 required 0", rf_we);
        end
        @(posedge clk);
`endif
        @(negedge clk);
        n_cmp++;
        if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 4'd5, 24'h001234}) begin
            n_fail++;
            $display("FAIL basic_write: we=%0b addr=%0h data=%0h required 1/5/001234", rf_we, rf_addr, rf_wdata);
        end
        idle(3);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flag_chain();
        logic [N-1:0] r = N'($urandom);
        push_op(24'h000000, 4'b0100, 4'd0, 1'b0, 1'b1, 4'd0);
        push_op(r, 4'b0000, 4'd3, 1'b1, 1'b0, 4'd1);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== {4'd3, r} || flags_q !== 4'b0100) begin
            n_fail++;
            $display("FAIL chain_eq: writes=%0d flags=%0h required 1 write to r3 data %0h flags 4",
                     obs_q.size(), flags_q, r);
        end
        exp_q.delete(); obs_q.delete();
        push_op(24'h000000, 4'b0100, 4'd0, 1'b0, 1'b1, 4'd0);
        push_op(r, 4'b0000, 4'd3, 1'b1, 1'b0, 4'd2);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 0 || squash_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL chain_ne: writes=%0d squash=%0d required 0 writes squash 1", obs_q.size(), squash_cnt);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reserved();
        push_op(N'($urandom), 4'b1011, 4'd7, 1'b1, 1'b1, 4'hF);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 0 || flags_q !== 4'b0100 || squash_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL reserved_cond: writes=%0d flags=%0h squash=%0d required 0/4/2",
                     obs_q.size(), flags_q, squash_cnt);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        logic [7:0] pattern = 8'h00;
        int         acc_cyc = -1;
        logic [N-1:0] r5 = N'($urandom);
        stall_force = 1'b1;
        for (int i = 0; i < 4; i++) push_op(N'($urandom), 4'b0000, ADDR_W'(i + 8), 1'b1, 1'b0, 4'd0);
        in_result = r5; in_flags = 4'b0000; in_rd = 4'd12; in_we = 1'b1;
        in_set_flags = 1'b0; in_cond = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_full: in_ready=%0b cycle %0d required 0", in_ready, i);
            end
        end
        @(posedge clk); #1;
        stall_force = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pattern[i] = rf_we;
            if (in_valid && in_ready) begin
                acc_cyc = i;
                model_accept(r5, 4'b0000, 4'd12, 1'b1, 1'b0, 4'd0);
            end
            @(posedge clk); #1;
            if (acc_cyc >= 0) in_valid = 1'b0;
        end
        n_cmp++;
        if (pattern !== 8'b0011_1110 || acc_cyc != 1) begin
            n_fail++;
            $display("FAIL bp_drain: we_pattern=%b accept_cycle=%0d required 00111110 / 1", pattern, acc_cyc);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        rand_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            push_op(N'($urandom), 4'($urandom), ADDR_W'($urandom), 1'($urandom),
                    1'($urandom), 4'($urandom_range(0, 15)));
        end
        rand_en = 1'b0;
        idle(DEPTH + 4);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: writes=%0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            n_cmp++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rand_write[%0d]: got %h required %h", k, obs_q[k], exp_q[k]);
            end
        end
        n_cmp++;
        if (flags_q !== m_flags || squash_cnt !== 16'(m_squash)) begin
            n_fail++;
            $display("FAIL rand_state: flags=%0h squash=%0d required %0h / %0d", flags_q, squash_cnt, m_flags, m_squash);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65537; i++) push_op(N'(i), 4'($urandom), 4'd1, 1'b1, 1'($urandom), 4'hF);
        idle(4);
        n_cmp++;
        if (squash_cnt !== 16'hFFFF || obs_q.size() != 0 || flags_q !== m_flags) begin
            n_fail++;
            $display("FAIL saturation: squash=%0h writes=%0d flags=%0h required FFFF / 0 / %0h",
                     squash_cnt, obs_q.size(), flags_q, m_flags);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_flag_chain();
        test_reserved();
        test_backpressure();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
